spi_transaction_arbiter: RTL and testbench

//   Shares one bidirectional_spi core between NUM_REQ fabric requesters.

---
 rtl/spi_transaction_arbiter_if.sv | 35 +++
 rtl/spi_transaction_arbiter.sv | 131 +++++++++++++
 tb/tb_spi_transaction_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_transaction_arbiter_if.sv
// rtl/spi_transaction_arbiter_if.sv - requester, response and SPI core signals of the arbiter
interface spi_transaction_arbiter_if #(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6
);
  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length;
  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data;
  logic [NUM_REQ*DATA_WIDTH-1:0]            req_rw_mask;
  logic [NUM_REQ-1:0]                       rsp_valid;
  logic [DATA_WIDTH-1:0]                    rsp_read_data;
  logic                                     rsp_error;
  logic [TRANSACTION_LEN_WIDTH-1:0]         spi_transaction_length;
  logic [DATA_WIDTH-1:0]                    spi_transaction_data;
  logic [DATA_WIDTH-1:0]                    spi_transaction_rw_mask;
  logic                                     spi_done;
  logic [DATA_WIDTH-1:0]                    spi_read_data;
  logic                                     busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_length, req_data, req_rw_mask, spi_done, spi_read_data,
    output req_ready, rsp_valid, rsp_read_data, rsp_error,
           spi_transaction_length, spi_transaction_data, spi_transaction_rw_mask, busy
  );

  // Requester fabric and SPI core side.
  modport master (
    output req_valid, req_length, req_data, req_rw_mask, spi_done, spi_read_data,
    input  req_ready, rsp_valid, rsp_read_data, rsp_error,
           spi_transaction_length, spi_transaction_data, spi_transaction_rw_mask, busy
  );
endinterface

// File: rtl/spi_transaction_arbiter.sv
// rtl/spi_transaction_arbiter.sv - round-robin arbiter sharing one SPI core between requesters
// One transaction in flight; completion or timeout is reported back to the granted requester.
module spi_transaction_arbiter #(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input  logic                     fabric_clk,
  input  logic                     reset_n,
  spi_transaction_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = TRANSACTION_LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_q, grant_q, grant_d;
  logic                  grant_found;
  logic [CW-1:0]         cnt_q;
  logic [LW-1:0]         len_q;
  logic [DATA_WIDTH-1:0] data_q, mask_q, rdata_q;
  logic                  err_q, reject_q;
  logic [LW-1:0]         sel_len;
  logic                  sel_bad;
  logic                  timeout;

  // First pending requester at or above the rr pointer, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_d     = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_d     = GW'(idx);
      end
    end
  end

  assign sel_len = bus.req_length[grant_d*LW +: LW];
  assign sel_bad = (sel_len == '0) || (int'(sel_len) > DATA_WIDTH);
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign bus.spi_transaction_data    = data_q;
  assign bus.spi_transaction_rw_mask = mask_q;
  assign bus.rsp_read_data           = rdata_q;

  always_ff @(posedge fabric_clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d                    = state_q;
    bus.req_ready              = '0;
    bus.rsp_valid              = '0;
    bus.rsp_error              = 1'b0;
    bus.spi_transaction_length = '0;
    bus.busy                   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_found) state_d = sel_bad ? RESPOND : ISSUE;
      end
      ISSUE: begin
        bus.req_ready[grant_q]     = 1'b1;
        bus.spi_transaction_length = len_q;
        state_d                    = WAIT;
      end
      WAIT: begin
        if (bus.spi_done || timeout) state_d = RESPOND;
      end
      RESPOND: begin
        // Rejected requests never saw ISSUE, so they are accepted here.
        bus.req_ready[grant_q] = reject_q;
        bus.rsp_valid[grant_q] = 1'b1;
        bus.rsp_error          = err_q;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk) begin
    if (!reset_n) begin
      rr_q     <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            grant_q  <= grant_d;
            len_q    <= sel_len;
            data_q   <= bus.req_data[grant_d*DATA_WIDTH +: DATA_WIDTH];
            mask_q   <= bus.req_rw_mask[grant_d*DATA_WIDTH +: DATA_WIDTH];
            rr_q     <= (grant_d == GW'(NUM_REQ - 1)) ? '0 : grant_d + 1'b1;
            reject_q <= sel_bad;
            err_q    <= sel_bad;
            if (sel_bad) rdata_q <= '0;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          // Completion takes priority over a timeout in the same cycle.
          if (bus.spi_done) begin
            rdata_q <= bus.spi_read_data;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// tb/tb_spi_transaction_arbiter.sv - scoreboard bench for spi_transaction_arbiter
// Instance a uses the default timeout, instance b a 16-cycle timeout.
`timescale 1ns/1ps
module tb_spi_transaction_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int LW = 6;

  typedef struct {
    logic [LW-1:0] len;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    int            delay;
    logic [DW-1:0] rdata;
  } iss_t;

  typedef struct {
    logic [NR-1:0] who;
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  iss_t          iss_q [2][$];
  rsp_t          rsp_q [2][$];
  int            core_cnt [2];
  logic [DW-1:0] core_rd [2];
  int            last_iss [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_transaction_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW)) ia ();
  spi_transaction_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW)) ib ();

  spi_transaction_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW),
                            .TIMEOUT_CYCLES(1024)) dut_a (
    .fabric_clk(clk), .reset_n(rst_a), .bus(ia));
  spi_transaction_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW),
                            .TIMEOUT_CYCLES(16)) dut_b (
    .fabric_clk(clk), .reset_n(rst_b), .bus(ib));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Core model plus issue/response monitor for instance d.
  task automatic monitor(input int d, input logic [NR-1:0] rv, input logic [DW-1:0] rd,
                         input logic re, input logic [LW-1:0] sl, input logic [DW-1:0] sd,
                         input logic [DW-1:0] sm, output logic done_o,
                         output logic [DW-1:0] rdata_o);
    iss_t e;
    rsp_t r;
    done_o  = 1'b0;
    rdata_o = '0;
    if (core_cnt[d] > 0) begin
      core_cnt[d]--;
      if (core_cnt[d] == 0) begin
        done_o  = 1'b1;
        rdata_o = core_rd[d];
      end
    end
    if (sl != '0) begin
      if (iss_q[d].size() == 0) begin
        fail($sformatf("unexpected_issue dut%0d len=%0d", d, sl));
      end else begin
        e = iss_q[d].pop_front();
        chk("issue_len", 64'(sl), 64'(e.len));
        chk("issue_data", 64'(sd), 64'(e.data));
        chk("issue_mask", 64'(sm), 64'(e.mask));
        last_iss[d] = cyc;
        core_cnt[d] = e.delay;
        core_rd[d]  = e.rdata;
      end
    end
    if (rv != '0) begin
      if (rsp_q[d].size() == 0) begin
        fail($sformatf("unexpected_rsp dut%0d rsp_valid=%b", d, rv));
      end else begin
        r = rsp_q[d].pop_front();
        chk("rsp_valid", 64'(rv), 64'(r.who));
        chk("rsp_read_data", 64'(rd), 64'(r.data));
        chk("rsp_error", 64'(re), 64'(r.err));
        if (r.lat >= 0) chk("rsp_latency", 64'(cyc - last_iss[d]), 64'(r.lat));
      end
    end
  endtask

  always @(negedge clk) begin
    logic          dn;
    logic [DW-1:0] rdv;
    monitor(0, ia.rsp_valid, ia.rsp_read_data, ia.rsp_error, ia.spi_transaction_length,
            ia.spi_transaction_data, ia.spi_transaction_rw_mask, dn, rdv);
    ia.spi_done      = dn;
    ia.spi_read_data = rdv;
  end

  always @(negedge clk) begin
    logic          dn;
    logic [DW-1:0] rdv;
    monitor(1, ib.rsp_valid, ib.rsp_read_data, ib.rsp_error, ib.spi_transaction_length,
            ib.spi_transaction_data, ib.spi_transaction_rw_mask, dn, rdv);
    ib.spi_done      = dn;
    ib.spi_read_data = rdv;
  end

  // Raise a request and queue the hand-computed issue and response it must produce.
  task automatic req(input int d, input int i, input logic [LW-1:0] len,
                     input logic [DW-1:0] data, input logic [DW-1:0] mask,
                     input bit issued, input int delay, input logic [DW-1:0] rdata,
                     input bit want_rsp, input logic err, input logic [DW-1:0] exp_rd,
                     input int lat);
    iss_t e;
    rsp_t r;
    if (d == 0) begin
      ia.req_length[i*LW +: LW]  = len;
      ia.req_data[i*DW +: DW]    = data;
      ia.req_rw_mask[i*DW +: DW] = mask;
      ia.req_valid[i]            = 1'b1;
    end else begin
      ib.req_length[i*LW +: LW]  = len;
      ib.req_data[i*DW +: DW]    = data;
      ib.req_rw_mask[i*DW +: DW] = mask;
      ib.req_valid[i]            = 1'b1;
    end
    if (issued) begin
      e.len = len; e.data = data; e.mask = mask; e.delay = delay; e.rdata = rdata;
      iss_q[d].push_back(e);
    end
    if (want_rsp) begin
      r.who = NR'(1) << i; r.data = exp_rd; r.err = err; r.lat = lat;
      rsp_q[d].push_back(r);
    end
  endtask

  task automatic drain(input int d);
    logic [NR-1:0] v;
    v = '1;
    for (int n = 0; n < 300 && v != '0; n++) begin
      @(negedge clk);
      if (d == 0) begin ia.req_valid = ia.req_valid & ~ia.req_ready; v = ia.req_valid; end
      else        begin ib.req_valid = ib.req_valid & ~ib.req_ready; v = ib.req_valid; end
    end
    if (v != '0) fail($sformatf("req_ready_timeout dut%0d pending=%b", d, v));
  endtask

  task automatic settle(input int d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = (rsp_q[d].size() == 0) && ((d == 0) ? !ia.busy : !ib.busy);
    end
    if (!ok) fail($sformatf("response_timeout dut%0d", d));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    @(posedge clk); #1 rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_req_ready"}, 64'(ia.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(ia.rsp_valid), 64'(0));
    chk({tag, "_rsp_read_data"}, 64'(ia.rsp_read_data), 64'(0));
    chk({tag, "_rsp_error"}, 64'(ia.rsp_error), 64'(0));
    chk({tag, "_spi_len"}, 64'(ia.spi_transaction_length), 64'(0));
    chk({tag, "_spi_data"}, 64'(ia.spi_transaction_data), 64'(0));
    chk({tag, "_spi_mask"}, 64'(ia.spi_transaction_rw_mask), 64'(0));
    chk({tag, "_busy"}, 64'(ia.busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ia.req_valid = '0; ia.req_length = '0; ia.req_data = '0; ia.req_rw_mask = '0;
    ib.req_valid = '0; ib.req_length = '0; ib.req_data = '0; ib.req_rw_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_a("por");
    chk("por_busy_b", 64'(ib.busy), 64'(0));
    @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write: length visible one cycle after req_valid is sampled, response 21 cycles after issue.
    req(0, 0, 8, 32'hA5, 32'hFF, 1, 20, 32'h5A5A_0001, 1, 1'b0, 32'h5A5A_0001, 21);
    @(posedge clk);
    @(negedge clk);
    chk("t1_issue_len", 64'(ia.spi_transaction_length), 64'(8));
    chk("t1_req_ready", 64'(ia.req_ready), 64'(4'b0001));
    chk("t1_busy", 64'(ia.busy), 64'(1));
    ia.req_valid[0] = 1'b0;
    settle(0);

    // All four requesting: grants 0,1,2,3; then 0 and 2 re-request.
    reset_a();
    for (int i = 0; i < NR; i++)
      req(0, i, LW'(8 + i), DW'(32'h100 + i), 32'hFF, 1, 3, DW'(32'hC0DE_0000 + i),
          1, 1'b0, DW'(32'hC0DE_0000 + i), 4);
    drain(0);
    settle(0);
    req(0, 0, 5, 32'h200, 32'h1F, 1, 3, 32'hAAAA_0000, 1, 1'b0, 32'hAAAA_0000, 4);
    req(0, 2, 7, 32'h202, 32'h7F, 1, 3, 32'hAAAA_0002, 1, 1'b0, 32'hAAAA_0002, 4);
    drain(0);
    settle(0);

    // Length bounds: 0 and 33 rejected without core activity, 32 accepted.
    reset_a();
    req(0, 1, 0, 32'h1111, 32'hFFFF, 0, 0, 32'h0, 1, 1'b1, 32'h0, -1);
    req(0, 2, 33, 32'h2222, 32'hFFFF, 0, 0, 32'h0, 1, 1'b1, 32'h0, -1);
    req(0, 3, 32, 32'hDEAD_BEEF, 32'hFFFF_0000, 1, 2, 32'h0000_BEEF, 1, 1'b0,
        32'h0000_BEEF, 3);
    drain(0);
    settle(0);

    // Reset in WAIT: no response, late spi_done ignored, grant restarts from requester 0.
    req(0, 0, 8, 32'h3333, 32'hFF, 1, 10, 32'h9999_9999, 0, 1'b0, 32'h0, -1);
    drain(0);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_a("wait_rst");
    @(posedge clk); #1 rst_a = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", 64'(ia.busy), 64'(0));
    @(posedge clk); #1;
    req(0, 0, 4, 32'h4440, 32'hF, 1, 2, 32'h0000_0040, 1, 1'b0, 32'h0000_0040, 3);
    req(0, 1, 4, 32'h4441, 32'hF, 1, 2, 32'h0000_0041, 1, 1'b0, 32'h0000_0041, 3);
    drain(0);
    settle(0);

    // spi_done in the same cycle as the 16-cycle timeout: done wins.
    req(1, 2, 16, 32'h0000_ABCD, 32'hFF00, 1, 16, 32'h1234, 1, 1'b0, 32'h1234, 17);
    drain(1);
    settle(1);

    // Core never answers: error after 16 WAIT cycles, queued request then completes.
    req(1, 0, 8, 32'h11, 32'hFF, 1, 0, 32'h0, 1, 1'b1, 32'h0, 17);
    req(1, 1, 4, 32'h22, 32'hF, 1, 5, 32'h77, 1, 1'b0, 32'h77, 6);
    drain(1);
    settle(1);

    chk("issue_queue_a_empty", 64'(iss_q[0].size()), 64'(0));
    chk("issue_queue_b_empty", 64'(iss_q[1].size()), 64'(0));
    chk("rsp_queue_a_empty", 64'(rsp_q[0].size()), 64'(0));
    chk("rsp_queue_b_empty", 64'(rsp_q[1].size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
